// File: rtl/alu_pkg.sv
// Shared ALUControl encoding for the RV32I ALU and its decoder.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + (i_sub ? ~b + 1 : b), with carry-out and signed overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  // Subtraction injects its +1 through the carry-in, so carry-out is the not-borrow.
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  assign o_sum      = w_full[WIDTH-1:0];
  assign o_carry    = w_full[WIDTH];
  assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// RV32I ALU: combinational result and flags, plus registered copies of y and zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] ALUControl,
  output logic [WIDTH-1:0]    y,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic [WIDTH-1:0]    y_q,
  output logic                zero_q
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic             w_arith;
  logic [ShW-1:0]   w_shamt;
  logic [WIDTH-1:0] r_y_q;
  logic             r_zero_q;

  assign w_op    = alu_op_e'(ALUControl);
  assign w_shamt = b[ShW-1:0];
  assign w_arith = (w_op == ALU_ADD) || (w_op == ALU_SUB) || (w_op == ALU_SLT);

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a       (a),
    .i_b       (b),
    .i_sub     (w_op != ALU_ADD),
    .o_sum     (w_sum),
    .o_carry   (w_carry),
    .o_overflow(w_ovf)
  );

  always_comb begin
    y = w_sum;
    case (w_op)
      ALU_ADD: y = w_sum;
      ALU_SUB: y = w_sum;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      // N xor V gives the true signed comparison even when the difference overflows.
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
      ALU_SLL: y = a << w_shamt;
      ALU_SRL: y = a >> w_shamt;
    endcase
  end

  assign zero     = (y == '0);
  assign carry    = w_arith & w_carry;
  assign overflow = w_arith & w_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y_q    <= '0;
      r_zero_q <= 1'b0;
    end else begin
      r_y_q    <= y;
      r_zero_q <= zero;
    end
  end

  assign y_q    = r_y_q;
  assign zero_q = r_zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, a behavioural reference model and literal pins.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  ALUControl;
  logic [31:0] y, y_q;
  logic        zero, carry, overflow, zero_q;

  int n_tests = 0;
  int n_fail  = 0;
  event do_check;

  alu #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .ALUControl(ALUControl),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .y_q       (y_q),
    .zero_q    (zero_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic        z;
    logic        c;
    logic        v;
  } res_t;

  function automatic logic out_of_range(longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference model from the arithmetic definitions, using wide signed/unsigned math.
  function automatic res_t model(logic [2:0] op, logic [31:0] ma, logic [31:0] mb);
    res_t   r;
    longint sa, sb;
    logic [32:0] wide;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    r  = '0;
    case (op)
      3'd0: begin
        wide = {1'b0, ma} + {1'b0, mb};
        r.y  = wide[31:0];
        r.c  = wide[32];
        r.v  = out_of_range(sa + sb);
      end
      3'd1: begin
        r.y = ma - mb;
        r.c = (ma >= mb);
        r.v = out_of_range(sa - sb);
      end
      3'd2: r.y = ma & mb;
      3'd3: r.y = ma | mb;
      3'd4: r.y = ma ^ mb;
      3'd5: begin
        r.y = (sa < sb) ? 32'd1 : 32'd0;
        r.c = (ma >= mb);
        r.v = out_of_range(sa - sb);
      end
      3'd6: r.y = ma << mb[4:0];
      default: r.y = ma >> mb[4:0];
    endcase
    r.z = (r.y == 32'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-output model.
  logic [31:0] m_yq;
  logic        m_zq;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_yq <= 32'd0;
      m_zq <= 1'b0;
    end else begin
      m_yq <= model(ALUControl, a, b).y;
      m_zq <= model(ALUControl, a, b).z;
    end
  end

  always @(do_check) begin
    res_t e;
    e = model(ALUControl, a, b);
    chk("model_y", y, e.y);
    chk("model_zero", {31'd0, zero}, {31'd0, e.z});
    chk("model_carry", {31'd0, carry}, {31'd0, e.c});
    chk("model_ovf", {31'd0, overflow}, {31'd0, e.v});
    chk("model_y_q", y_q, m_yq);
    chk("model_zero_q", {31'd0, zero_q}, {31'd0, m_zq});
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV] = '{
    '{3'd0, 32'd10,         32'd6,          32'd16,         1'b0, 1'b0, 1'b0},
    '{3'd1, 32'd10,         32'd6,          32'd4,          1'b0, 1'b1, 1'b0},
    '{3'd2, 32'd10,         32'd6,          32'd2,          1'b0, 1'b0, 1'b0},
    '{3'd3, 32'd10,         32'd6,          32'd14,         1'b0, 1'b0, 1'b0},
    '{3'd5, 32'd10,         32'd6,          32'd0,          1'b1, 1'b1, 1'b0},
    '{3'd5, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b1, 1'b0},
    '{3'd5, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0, 1'b0},
    '{3'd5, 32'h80000000,   32'h7FFFFFFF,   32'd1,          1'b0, 1'b1, 1'b1},
    '{3'd0, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b1, 1'b0},
    '{3'd1, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 1'b1, 1'b1},
    '{3'd1, 32'd5,          32'd5,          32'd0,          1'b1, 1'b1, 1'b0},
    '{3'd4, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1'b0, 1'b0, 1'b0},
    '{3'd6, 32'd1,          32'h23,         32'd8,          1'b0, 1'b0, 1'b0},
    '{3'd7, 32'h80000000,   32'd31,         32'd1,          1'b0, 1'b0, 1'b0},
    '{3'd6, 32'hDEADBEEF,   32'd0,          32'hDEADBEEF,   1'b0, 1'b0, 1'b0},
    '{3'd7, 32'hDEADBEEF,   32'hFFFFFFE0,   32'hDEADBEEF,   1'b0, 1'b0, 1'b0},
    '{3'd6, 32'd1,          32'd31,         32'h80000000,   1'b0, 1'b0, 1'b0},
    '{3'd4, 32'd10,         32'd6,          32'd12,         1'b0, 1'b0, 1'b0},
    '{3'd0, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b0, 1'b1}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a = 32'd0;
    b = 32'd0;
    ALUControl = 3'd0;
    @(negedge clk);
    #1;
    chk("reset_y_q", y_q, 32'd0);
    chk("reset_zero_q", {31'd0, zero_q}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ALUControl = vecs[i].op;
      a = vecs[i].a;
      b = vecs[i].b;
      #1;
      ->do_check;
      chk($sformatf("vec%0d_y", i), y, vecs[i].y);
      chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("vec%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].c});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].v});
    end

    // Last vector leaves y = 0x80000000; let it register, then reset asynchronously.
    @(posedge clk);
    #1;
    chk("pre_reset_y_q", y_q, 32'h80000000);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_y_q", y_q, 32'd0);
    chk("async_reset_zero_q", {31'd0, zero_q}, 32'd0);
    chk("reset_comb_y", y, 32'h80000000);
    ->do_check;
    @(posedge clk);
    #1;
    chk("held_reset_y_q", y_q, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    ALUControl = 3'd0;
    a = 32'd10;
    b = 32'd6;
    #1;
    ->do_check;
    @(posedge clk);
    #1;
    chk("release_y_q", y_q, 32'd16);
    chk("release_zero_q", {31'd0, zero_q}, 32'd0);
    ->do_check;
    a = 32'd1;
    b = 32'd1;
    #1;
    chk("between_edges_y", y, 32'd2);
    chk("between_edges_y_q", y_q, 32'd16);
    ->do_check;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RV32I single-cycle datapath; selects one of eight operations via a 3-bit ALUControl code.
- Result y and condition flags are combinational, with zero-cycle latency, so the single-cycle datapath can use them within the same cycle.
- Registered copies of the result and flags are provided for debug/trace and for later pipelining; they are the only clocked state.

Parameters:
- WIDTH, 32, operand/result width in bits; the shift amount uses the low $clog2(WIDTH) bits of b.

Ports:
- clk  input  1  rising-edge clock for registered copies
- reset  input  1  asynchronous, active-high; clears registered outputs
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ALUControl  input  3  operation select
- y  output  WIDTH  combinational result
- zero  output  1  combinational; 1 when y == 0
- carry  output  1  combinational; carry-out of the adder for add, not-borrow for sub/slt, 0 otherwise
- overflow  output  1  combinational; signed overflow for add/sub/slt, 0 otherwise
- y_q  output  WIDTH  registered y
- zero_q  output  1  registered zero

Behaviour:
- ALUControl encoding (all arithmetic modulo 2^WIDTH):
  - 000 add: y = a + b
  - 001 sub: y = a - b, computed as a + ~b + 1
  - 010 and: y = a & b
  - 011 or: y = a | b
  - 100 xor: y = a ^ b
  - 101 slt: y = {0…0, signed(a) < signed(b)}
  - 110 sll: y = a << b[4:0]
  - 111 srl: y = a >> b[4:0], logical
- slt derives its result from the subtractor as N xor V, so it is correct across sign boundaries.
- All eight codes are defined; there is no default-to-X.
- Combinational outputs settle within the same delta as input change; no clock is needed for y, zero, carry or overflow.
- overflow for add: sign(a) == sign(b) and sign(y) != sign(a).
- overflow for sub/slt: sign(a) != sign(b) and sign(diff) != sign(a).
- On each clk rising edge: y_q <= y, zero_q <= zero.
- While reset = 1: y_q = 0 and zero_q = 0 immediately, without waiting for clk.
- Reset deassertion: the registers load on the next clk edge.
- Reset does not affect the combinational outputs.
- Reset mid-operation: combinational outputs keep tracking the inputs; registered outputs are held at 0 until reset deasserts.
- Boundaries:
  - add 0xFFFFFFFF + 1: y = 0, zero = 1, carry = 1.
  - sub 0x80000000 - 1: y = 0x7FFFFFFF, overflow = 1.
  - Shift by 0 returns a; shift by 31 is valid; b[31:5] are ignored.

Decomposition:
- Shared package alu_pkg holds the ALUControl enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL) so the decoder and the ALU agree on the encoding.
- One natural sub-module: alu_addsub, the shared adder/subtractor producing sum, carry and overflow, reused by add, sub and slt.
- Shifts, logic ops and the output mux stay in alu.

Test Plan:
- a=10, b=6; ALUControl 000,001,010,011,101, each sampled #1 after change -> y = 16, 4, 2, 14, 0 respectively.
- slt signed: a=0xFFFFFFFF (-1), b=1 -> y = 1; swap operands -> y = 0.
- a=0x80000000, b=0x7FFFFFFF -> y = 1, overflow = 1.
- Edge arithmetic:
  - add 0xFFFFFFFF + 1 -> y = 0, zero = 1, carry = 1.
  - sub 0x80000000 - 1 -> y = 0x7FFFFFFF, overflow = 1.
  - sub 5 - 5 -> zero = 1.
- xor/shifts:
  - xor 0xF0F0F0F0 ^ 0xFF00FF00 -> 0x0FF00FF0.
  - sll 1 by b = 0x23 (uses 3) -> 8.
  - srl 0x80000000 by 31 -> 1 (logical, no sign fill).
- Registers:
  - assert reset async mid-cycle -> y_q = 0 and zero_q = 0 without a clk edge.
  - release reset, apply a=10, b=6, add, one clk edge -> y_q = 16, zero_q = 0.
  - y changes between edges while y_q holds.
